// File: rtl/bg_pkg.sv
// Shared definitions for the background estimator and the downstream pe stage:
// one-hot state encoding and default widths.
package bg_pkg;

  // Width of the expected-colour bus consumed by pe (red_exp/green_exp/blue_exp).
  localparam int PE_EXP_W         = 9;
  localparam int PIX_W_DEF        = 8;
  localparam int EXP_W_DEF        = PE_EXP_W;
  localparam int LOG2_SAMPLES_DEF = 4;

  // One-hot so the Q indicators come straight off the state flops.
  typedef enum logic [3:0] {
    S_INI  = 4'b0001,
    S_ACC  = 4'b0010,
    S_DIV  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/bg_channel_stat.sv
// Per-channel statistics: running sum, min/max, rounded mean and spread.
// clr re-arms the sample set, en accepts a sample, fin registers the results.
module bg_channel_stat
  import bg_pkg::*;
#(
  parameter int PIX_W        = PIX_W_DEF,
  parameter int EXP_W        = EXP_W_DEF,
  parameter int LOG2_SAMPLES = LOG2_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             fin,
  input  logic [PIX_W-1:0] pix,
  output logic [EXP_W-1:0] exp_val,
  output logic [PIX_W-1:0] spread
);

  localparam int ACC_W = PIX_W + LOG2_SAMPLES;
  // One spare bit so adding the rounding half can never wrap.
  localparam int RND_W = ACC_W + 1;
  localparam logic [RND_W-1:0] HALF = RND_W'(1) << (LOG2_SAMPLES - 1);

  logic [ACC_W-1:0] acc;
  logic [PIX_W-1:0] min_v;
  logic [PIX_W-1:0] max_v;
  logic [RND_W-1:0] rnd_sum;
  logic [RND_W-1:0] quot;
  logic [PIX_W-1:0] mean_sat;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      min_v <= '0;
      max_v <= '0;
    end else if (clr) begin
      acc   <= '0;
      min_v <= '1;
      max_v <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(pix);
      if (pix < min_v) min_v <= pix;
      if (pix > max_v) max_v <= pix;
    end
  end

  always_comb begin
    rnd_sum  = {1'b0, acc} + HALF;
    quot     = rnd_sum >> LOG2_SAMPLES;
    mean_sat = (|quot[RND_W-1:PIX_W]) ? '1 : quot[PIX_W-1:0];
  end

  // Results hold from one DIV to the next; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_val <= '0;
      spread  <= '0;
    end else if (fin) begin
      exp_val <= EXP_W'(mean_sat);
      spread  <= max_v - min_v;
    end
  end

endmodule

// File: rtl/bg_estimator.sv
// Background estimator: collects 2^LOG2_SAMPLES reference pixels and reports the
// rounded per-channel mean (pe's expected colour) and per-channel spread.
module bg_estimator
  import bg_pkg::*;
#(
  parameter int PIX_W        = PIX_W_DEF,
  parameter int EXP_W        = EXP_W_DEF,
  parameter int LOG2_SAMPLES = LOG2_SAMPLES_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] red_in,
  input  logic [PIX_W-1:0] green_in,
  input  logic [PIX_W-1:0] blue_in,
  output logic             pix_ready,
  output logic [EXP_W-1:0] red_exp,
  output logic [EXP_W-1:0] green_exp,
  output logic [EXP_W-1:0] blue_exp,
  output logic [PIX_W-1:0] red_spread,
  output logic [PIX_W-1:0] green_spread,
  output logic [PIX_W-1:0] blue_spread,
  output logic             Done,
  output logic             Qi,
  output logic             Qacc,
  output logic             Qdiv,
  output logic             Qd
);

  state_t                  state;
  state_t                  state_nxt;
  logic [LOG2_SAMPLES-1:0] count;
  logic                    accept;
  logic                    last;
  logic                    clr;
  logic                    fin;

  assign accept = pix_valid && (state == S_ACC);
  // count wraps to 0 on the final sample; INI clears it anyway.
  assign last   = accept && (count == '1);
  assign clr    = (state == S_INI);
  assign fin    = (state == S_DIV);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_INI;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INI:   if (Start) state_nxt = S_ACC;
      S_ACC:   if (last)  state_nxt = S_DIV;
      S_DIV:              state_nxt = S_DONE;
      S_DONE:  if (Ack)   state_nxt = S_INI;
      default:            state_nxt = S_INI;
    endcase
  end

  // Outputs are taken directly from the one-hot state flops.
  always_comb begin
    Qi        = state[0];
    Qacc      = state[1];
    Qdiv      = state[2];
    Qd        = state[3];
    pix_ready = state[1];
    Done      = state[3];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      count <= '0;
    else if (clr)    count <= '0;
    else if (accept) count <= count + LOG2_SAMPLES'(1);
  end

  bg_channel_stat #(.PIX_W(PIX_W), .EXP_W(EXP_W), .LOG2_SAMPLES(LOG2_SAMPLES)) u_red (
    .clk(Clk), .rst_n(Reset), .clr(clr), .en(accept), .fin(fin),
    .pix(red_in), .exp_val(red_exp), .spread(red_spread)
  );

  bg_channel_stat #(.PIX_W(PIX_W), .EXP_W(EXP_W), .LOG2_SAMPLES(LOG2_SAMPLES)) u_green (
    .clk(Clk), .rst_n(Reset), .clr(clr), .en(accept), .fin(fin),
    .pix(green_in), .exp_val(green_exp), .spread(green_spread)
  );

  bg_channel_stat #(.PIX_W(PIX_W), .EXP_W(EXP_W), .LOG2_SAMPLES(LOG2_SAMPLES)) u_blue (
    .clk(Clk), .rst_n(Reset), .clr(clr), .en(accept), .fin(fin),
    .pix(blue_in), .exp_val(blue_exp), .spread(blue_spread)
  );

endmodule

// File: tb/tb_bg_estimator.sv
// Self-checking bench for bg_estimator: directed cases plus randomized runs,
// compared against an arithmetic mean/min/max model of the sample set.
module tb_bg_estimator;

  localparam int PIX_W = 8;
  localparam int EXP_W = 9;
  localparam int NS    = 16;

  logic             Clk = 1'b0;
  logic             Reset, Start, Ack, pix_valid;
  logic [PIX_W-1:0] red_in, green_in, blue_in;
  logic             pix_ready, Done, Qi, Qacc, Qdiv, Qd;
  logic [EXP_W-1:0] red_exp, green_exp, blue_exp;
  logic [PIX_W-1:0] red_spread, green_spread, blue_spread;

  int n_checks = 0;
  int n_fail   = 0;
  int smp[3][NS];

  always #5 Clk = ~Clk;

  bg_estimator #(.PIX_W(PIX_W), .EXP_W(EXP_W), .LOG2_SAMPLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .pix_valid(pix_valid),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .pix_ready(pix_ready),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .red_spread(red_spread), .green_spread(green_spread), .blue_spread(blue_spread),
    .Done(Done), .Qi(Qi), .Qacc(Qacc), .Qdiv(Qdiv), .Qd(Qd)
  );

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int ref_mean(input int ch);
    int sum = 0;
    for (int i = 0; i < NS; i++) sum += smp[ch][i];
    sum = (sum + NS / 2) / NS;
    return (sum > 255) ? 255 : sum;
  endfunction

  function automatic int ref_spread(input int ch);
    int lo = 255;
    int hi = 0;
    for (int i = 0; i < NS; i++) begin
      if (smp[ch][i] < lo) lo = smp[ch][i];
      if (smp[ch][i] > hi) hi = smp[ch][i];
    end
    return hi - lo;
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_red_exp"},      int'(red_exp),      ref_mean(0));
    check({tag, "_green_exp"},    int'(green_exp),    ref_mean(1));
    check({tag, "_blue_exp"},     int'(blue_exp),     ref_mean(2));
    check({tag, "_red_spread"},   int'(red_spread),   ref_spread(0));
    check({tag, "_green_spread"}, int'(green_spread), ref_spread(1));
    check({tag, "_blue_spread"},  int'(blue_spread),  ref_spread(2));
  endtask

  task automatic fill_const(input int r, input int g, input int b);
    for (int i = 0; i < NS; i++) begin
      smp[0][i] = r; smp[1][i] = g; smp[2][i] = b;
    end
  endtask

  task automatic drive_garbage();
    red_in   = PIX_W'($urandom);
    green_in = PIX_W'($urandom);
    blue_in  = PIX_W'($urandom);
  endtask

  // From INI (1 time unit after an edge): pulse Start and confirm ACC.
  task automatic start_acc(input bit hold_start);
    Start = 1'b1;
    pix_valid = 1'b1;
    drive_garbage();
    @(posedge Clk); #1;
    check("enter_acc", int'(Qacc), 1);
    if (!hold_start) Start = 1'b0;
  endtask

  // Offers samples 0..n-1; gap_mode 0 = continuous, 1 = every other cycle, 2 = random.
  task automatic feed(input int n, input int gap_mode);
    int idx = 0;
    int cyc = 0;
    bit vld;
    bit rdy;
    while (idx < n && cyc < 400) begin
      case (gap_mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 2 == 0);
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      pix_valid = vld;
      if (vld) begin
        red_in   = PIX_W'(smp[0][idx]);
        green_in = PIX_W'(smp[1][idx]);
        blue_in  = PIX_W'(smp[2][idx]);
      end else begin
        drive_garbage();
      end
      rdy = pix_ready;
      if (cyc < 4 || gap_mode == 1) check("pix_ready_in_acc", int'(rdy), 1);
      @(posedge Clk); #1;
      if (vld && rdy) idx++;
      cyc++;
    end
    check("feed_accepted", idx, n);
    // Keep offering junk so any extra acceptance would corrupt the results.
    pix_valid = 1'b1;
    drive_garbage();
  endtask

  // Right after the final acceptance: DIV, then DONE with results, then Ack.
  task automatic finish(input string tag, input int ack_delay, input bit ack_with_start);
    check({tag, "_qdiv"},  int'(Qdiv), 1);
    check({tag, "_ready_low"}, int'(pix_ready), 0);
    check({tag, "_done_early"}, int'(Done), 0);
    @(posedge Clk); #1;
    check({tag, "_qd"},   int'(Qd), 1);
    check({tag, "_done"}, int'(Done), 1);
    check_results(tag);
    for (int i = 0; i < ack_delay; i++) begin
      drive_garbage();
      @(posedge Clk); #1;
      check({tag, "_hold_qd"}, int'(Qd), 1);
      check({tag, "_hold_red"}, int'(red_exp), ref_mean(0));
    end
    Ack = 1'b1;
    Start = ack_with_start;
    @(posedge Clk); #1;
    Ack = 1'b0;
    check({tag, "_ack_ini"}, int'(Qi), 1);
    check({tag, "_ack_done_fall"}, int'(Done), 0);
    check({tag, "_keep_blue"}, int'(blue_exp), ref_mean(2));
  endtask

  task automatic full_run(input string tag, input int gap_mode);
    start_acc(1'b0);
    feed(NS, gap_mode);
    finish(tag, 0, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Ack = 1'b0; pix_valid = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0;
    #12;
    check("rst_qi", int'(Qi), 1);
    check("rst_qacc", int'(Qacc), 0);
    check("rst_ready", int'(pix_ready), 0);
    check("rst_done", int'(Done), 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Ramp: red 0..15, green 15..0, blue 255.
    for (int i = 0; i < NS; i++) begin
      smp[0][i] = i; smp[1][i] = NS - 1 - i; smp[2][i] = 255;
    end
    full_run("ramp", 0);
    check("ramp_const_red", int'(red_exp), 8);

    // Abort mid-ACC after 5 samples.
    fill_const(77, 88, 99);
    start_acc(1'b0);
    feed(5, 0);
    #2 Reset = 1'b0;
    #1;
    check("abort_qi", int'(Qi), 1);
    check("abort_qacc", int'(Qacc), 0);
    check("abort_ready", int'(pix_ready), 0);
    check("abort_red_exp", int'(red_exp), 0);
    check("abort_green_spread", int'(green_spread), 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("post_abort_qi", int'(Qi), 1);

    fill_const(100, 150, 200);
    full_run("flat", 0);

    // Rounding boundary: sum 8 rounds up to 1, sum 7 rounds down to 0.
    fill_const(0, 0, 0);
    smp[0][3] = 8; smp[1][9] = 7; smp[2][15] = 8;
    full_run("round", 0);
    check("round_up_const", int'(red_exp), 1);
    check("round_dn_const", int'(green_exp), 0);

    // Alternate-cycle valid.
    for (int i = 0; i < NS; i++)
      for (int c = 0; c < 3; c++) smp[c][i] = $urandom_range(0, 255);
    full_run("toggle", 1);

    // Start held through ACC and DONE; late Ack with Start high.
    for (int i = 0; i < NS; i++)
      for (int c = 0; c < 3; c++) smp[c][i] = $urandom_range(0, 255);
    start_acc(1'b1);
    feed(NS, 0);
    finish("hold", 10, 1'b1);
    @(posedge Clk); #1;
    check("hold_restart_acc", int'(Qacc), 1);
    Start = 1'b0;
    fill_const(255, 255, 255);
    feed(NS, 0);
    finish("max", 0, 1'b0);
    check("max_const", int'(green_exp), 255);

    fill_const(0, 0, 0);
    full_run("zero", 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++)
        for (int c = 0; c < 3; c++) smp[c][i] = $urandom_range(0, 255);
      full_run("rand", 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bg_estimator.md
Name: bg_estimator

Overview:
- Upstream stage of the background-removal processing element (pe).
- Accepts a stream of 2^LOG2_SAMPLES reference pixels (background-only samples) and computes the rounded mean per channel.
- Results drive pe's red_exp/green_exp/blue_exp inputs. Done is the trigger for pe's Start_BgRemoval.
- Per-channel spread (max minus min) is also reported, so software/test can pick pe's threshold.

Parameters:
- PIX_W, 8, bits per colour channel of incoming pixels
- EXP_W, 9, width of expected-colour outputs (matches pe red_exp/green_exp/blue_exp)
- LOG2_SAMPLES, 4, log2 of sample count (16 samples); legal range 1..8

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin estimation; sampled only in state INI
- Ack  in  1  consumer acknowledges result; sampled only in state DONE
- pix_valid  in  1  red_in/green_in/blue_in carry a sample this cycle
- red_in  in  PIX_W  sample red
- green_in  in  PIX_W  sample green
- blue_in  in  PIX_W  sample blue
- pix_ready  out  1  high in ACC only; a sample is accepted when pix_valid && pix_ready
- red_exp  out  EXP_W  rounded mean red, zero-extended
- green_exp  out  EXP_W  rounded mean green
- blue_exp  out  EXP_W  rounded mean blue
- red_spread  out  PIX_W  max-min red over the sample set
- green_spread  out  PIX_W  max-min green
- blue_spread  out  PIX_W  max-min blue
- Done  out  1  results valid; equals Qd
- Qi, Qacc, Qdiv, Qd  out  1 each  one-hot state indicators

Behaviour:
- Reset (Reset=0, async) forces:
  - state INI, so Qi=1 and the other Q outputs 0
  - all accumulators, count, min/max registers and outputs to 0
  - pix_ready=0, Done=0
- Reset asserted mid-operation aborts immediately. Partial sums are discarded; no result is produced.
- INI:
  - Clears the accumulators (width PIX_W+LOG2_SAMPLES) and the count.
  - Min registers are set to all-ones; max registers to 0.
  - Start=1 moves to ACC on the next edge. pix_valid is ignored in INI.
- ACC:
  - pix_ready=1.
  - Each accepted sample adds to each channel's accumulator, updates per-channel min/max, and increments the count.
  - Cycles with pix_valid=0 stall; there is no timeout.
  - When the 2^LOG2_SAMPLES-th sample is accepted, the next state is DIV. pix_ready drops in the cycle after that acceptance.
  - Start is ignored in ACC.
- DIV (exactly 1 cycle):
  - exp = (acc + 2^(LOG2_SAMPLES-1)) >> LOG2_SAMPLES. Compute this at PIX_W+LOG2_SAMPLES+1 bits so the rounding add cannot overflow.
  - The result is ≤ 2^PIX_W and is zero-extended to EXP_W. The value 256 is possible only if inputs exceed the max, so it never occurs; saturate to 2^PIX_W-1 regardless.
  - spread = max - min is registered.
  - Next state is DONE.
- DONE:
  - Done=1 and all result outputs are held stable.
  - Ack=1 moves to INI. Result outputs keep their values until the next DIV; only Done falls.
  - Start in DONE is ignored.
  - Ack and Start both high in DONE: go to INI only. Start must be re-asserted there.
- Latency: the first result is visible 2 edges after the final sample is accepted (ACC→DIV, DIV→DONE).
- Minimum throughput: 2^LOG2_SAMPLES + 3 cycles per estimate with continuous valid (INI, samples, DIV, and DONE with immediate Ack).
- All state outputs are registered and exactly one Q is high at all times.

Decomposition:
- Shared package bg_pkg:
  - state encoding constants (S_INI, S_ACC, S_DIV, S_DONE)
  - PIX_W/EXP_W defaults
  - a shared EXP_W constant also used by pe
- One sub-module, bg_channel_stat, instantiated three times (one per channel). It holds the accumulator, min, max, rounding divide and spread for one channel, with inputs clr, en, fin.
- The FSM and sample counter stay in bg_estimator.

Test Plan:
- Reset mid-ACC after 5 samples, then release → Qi=1, outputs 0. A fresh 16-sample run with all pixels (100,150,200) → exp=(100,150,200), spread=(0,0,0).
- Uniform ramp: red samples 0..15, green 15..0, blue constant 255 → red_exp=8 (120+8=128, >>4), green_exp=8, blue_exp=255, red_spread=15, green_spread=15, blue_spread=0.
- Rounding boundary: 15 samples of 0 and one of 8 (sum 8) → exp=1. One sample of 7 (sum 7) → exp=0.
- pix_valid toggled every other cycle → pix_ready high throughout ACC. Exactly 16 accepted samples. Done 2 edges after the 16th acceptance; no extra samples consumed.
- Start held high during ACC and DONE, Ack delayed 10 cycles → state stays DONE and outputs stable. Ack with Start=1 → INI for exactly 1 cycle, then ACC.
- Extremes: all samples 255 → exp=255 with no overflow; all samples 0 → exp=0, spread=0.
